// File: rtl/ball_pkg.sv
// Shared types for the Breakout ball engine: direction encodings and the
// engine state enum.
package ball_pkg;

    localparam logic [1:0] DIR_UR = 2'b00;
    localparam logic [1:0] DIR_UL = 2'b01;
    localparam logic [1:0] DIR_DR = 2'b10;
    localparam logic [1:0] DIR_DL = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVE   = 3'd1,
        CHECK  = 3'd2,
        UPDATE = 3'd3,
        LOST   = 3'd4
    } state_e;

endpackage

// File: rtl/ball_brick_lookup.sv
// Combinational map from a candidate ball position to the brick cell it falls
// in. Each cell is a pair of range compares, so no divider is built.
module ball_brick_lookup
    import ball_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int BRICK_COLS = 4,
    parameter int BRICK_ROWS = 3,
    parameter int BRICK_W    = 160,
    parameter int BRICK_H    = 20,
    parameter int BRICK_X0   = 0,
    parameter int BRICK_Y0   = 400,
    parameter int IDX_W      = 4
) (
    input  logic signed [COORD_W:0] nx,
    input  logic signed [COORD_W:0] ny,
    output logic                    valid,
    output logic [IDX_W-1:0]        idx
);

    logic signed [31:0] sx;
    logic signed [31:0] sy;

    always_comb begin
        sx    = 32'(nx);
        sy    = 32'(ny);
        valid = 1'b0;
        idx   = '0;
        // Edges are inclusive-low, exclusive-high, so at most one cell matches.
        for (int r = 0; r < BRICK_ROWS; r++) begin
            for (int c = 0; c < BRICK_COLS; c++) begin
                if (sy >= BRICK_Y0 + r * BRICK_H && sy < BRICK_Y0 + (r + 1) * BRICK_H &&
                    sx >= BRICK_X0 + c * BRICK_W && sx < BRICK_X0 + (c + 1) * BRICK_W) begin
                    valid = 1'b1;
                    idx   = IDX_W'(r * BRICK_COLS + c);
                end
            end
        end
    end

endmodule

// File: rtl/ball_engine.sv
// Breakout ball engine: owns ball position/direction, steps once per frame
// tick, resolves wall/paddle/brick collisions and reports hits and misses.
module ball_engine
    import ball_pkg::*;
#(
    parameter int COORD_W     = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int XSTEP       = 1,
    parameter int YSTEP       = 1,
    parameter int PADDLE_Y    = 20,
    parameter int PADDLE_HALF = 40,
    parameter int BRICK_COLS  = 4,
    parameter int BRICK_ROWS  = 3,
    parameter int BRICK_W     = 160,
    parameter int BRICK_H     = 20,
    parameter int BRICK_X0    = 0,
    parameter int BRICK_Y0    = 400,
    localparam int NUM_BRICKS = BRICK_ROWS * BRICK_COLS,
    localparam int IDX_W      = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  launch,
    input  logic [COORD_W-1:0]    paddle_x,
    input  logic [NUM_BRICKS-1:0] brick_status,
    output logic [COORD_W-1:0]    ball_x,
    output logic [COORD_W-1:0]    ball_y,
    output logic [1:0]            dir,
    output logic                  in_play,
    output logic                  brick_hit,
    output logic [IDX_W-1:0]      brick_hit_idx,
    output logic                  ball_lost
);

    localparam int SW = COORD_W + 1;
    localparam int PW = COORD_W + 2;
    localparam logic signed [SW-1:0] XSTEP_S    = SW'(XSTEP);
    localparam logic signed [SW-1:0] YSTEP_S    = SW'(YSTEP);
    localparam logic signed [SW-1:0] X_MAX_S    = SW'(SCREEN_W - 1);
    localparam logic signed [SW-1:0] Y_MAX_S    = SW'(SCREEN_H - 1);
    localparam logic signed [SW-1:0] PAD_Y_S    = SW'(PADDLE_Y);
    localparam logic signed [PW-1:0] PAD_HALF_S = PW'(PADDLE_HALF);
    localparam logic [COORD_W-1:0]   XSTEP_U    = COORD_W'(XSTEP);
    localparam logic [COORD_W-1:0]   YSTEP_U    = COORD_W'(YSTEP);
    localparam logic [COORD_W-1:0]   SERVE_Y    = COORD_W'(PADDLE_Y + 1);

    // tick and launch are single-cycle strobes with no backpressure: launch is
    // honoured only in IDLE, tick only in MOVE; anything else is dropped.
    state_e             state_q, state_d;
    logic [1:0]         dir_q, dir_d;
    logic [COORD_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic               brick_hit_q, brick_hit_d;
    logic               ball_lost_q, ball_lost_d;
    logic               in_play_q, in_play_d;
    logic               pend_hit_q, pend_hit_d;
    logic [IDX_W-1:0]   brick_hit_idx_q, brick_hit_idx_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;

    logic signed [SW-1:0] nx, ny;
    logic signed [PW-1:0] nx_w, pad_lo, pad_hi;
    logic                 x_flip, top_flip, pad_zone, pad_hit, brick_take, brick_valid;
    logic [IDX_W-1:0]     brick_idx;

    assign nx = dir_q[0] ? $signed({1'b0, ball_x_q}) - XSTEP_S : $signed({1'b0, ball_x_q}) + XSTEP_S;
    assign ny = dir_q[1] ? $signed({1'b0, ball_y_q}) - YSTEP_S : $signed({1'b0, ball_y_q}) + YSTEP_S;

    // Paddle bounds may leave the screen on either side, hence the extra bit.
    assign nx_w   = {nx[SW-1], nx};
    assign pad_lo = $signed({2'b00, paddle_x}) - PAD_HALF_S;
    assign pad_hi = $signed({2'b00, paddle_x}) + PAD_HALF_S;

    assign x_flip     = nx[SW-1] || (nx > X_MAX_S);
    assign top_flip   = !dir_q[1] && (ny > Y_MAX_S);
    assign pad_zone   = dir_q[1] && (ny <= PAD_Y_S);
    assign pad_hit    = pad_zone && (nx_w >= pad_lo) && (nx_w <= pad_hi);
    assign brick_take = !top_flip && !pad_zone && brick_valid && brick_status[brick_idx];

    ball_brick_lookup #(
        .COORD_W    (COORD_W),
        .BRICK_COLS (BRICK_COLS),
        .BRICK_ROWS (BRICK_ROWS),
        .BRICK_W    (BRICK_W),
        .BRICK_H    (BRICK_H),
        .BRICK_X0   (BRICK_X0),
        .BRICK_Y0   (BRICK_Y0),
        .IDX_W      (IDX_W)
    ) u_lookup (
        .nx    (nx),
        .ny    (ny),
        .valid (brick_valid),
        .idx   (brick_idx)
    );

    always_comb begin
        state_d         = state_q;
        dir_d           = dir_q;
        ball_x_d        = ball_x_q;
        ball_y_d        = ball_y_q;
        brick_hit_d     = 1'b0;
        brick_hit_idx_d = brick_hit_idx_q;
        ball_lost_d     = 1'b0;
        pend_hit_d      = pend_hit_q;
        pend_idx_d      = pend_idx_q;
        case (state_q)
            IDLE: begin
                ball_x_d = paddle_x;
                ball_y_d = SERVE_Y;
                if (launch) begin
                    dir_d   = DIR_UR;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (tick) state_d = CHECK;
            end
            CHECK: begin
                if (pad_zone && !pad_hit) begin
                    ball_lost_d = 1'b1;
                    state_d     = LOST;
                end else begin
                    dir_d      = {dir_q[1] ^ (top_flip | pad_hit | brick_take), dir_q[0] ^ x_flip};
                    pend_hit_d = brick_take;
                    pend_idx_d = brick_idx;
                    state_d    = UPDATE;
                end
            end
            UPDATE: begin
                ball_x_d    = dir_q[0] ? ball_x_q - XSTEP_U : ball_x_q + XSTEP_U;
                ball_y_d    = dir_q[1] ? ball_y_q - YSTEP_U : ball_y_q + YSTEP_U;
                brick_hit_d = pend_hit_q;
                if (pend_hit_q) brick_hit_idx_d = pend_idx_q;
                pend_hit_d  = 1'b0;
                state_d     = MOVE;
            end
            LOST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_play_d = (state_d == MOVE) || (state_d == CHECK) || (state_d == UPDATE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            dir_q           <= DIR_UR;
            ball_x_q        <= '0;
            ball_y_q        <= SERVE_Y;
            brick_hit_q     <= 1'b0;
            brick_hit_idx_q <= '0;
            ball_lost_q     <= 1'b0;
            in_play_q       <= 1'b0;
            pend_hit_q      <= 1'b0;
            pend_idx_q      <= '0;
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            ball_x_q        <= ball_x_d;
            ball_y_q        <= ball_y_d;
            brick_hit_q     <= brick_hit_d;
            brick_hit_idx_q <= brick_hit_idx_d;
            ball_lost_q     <= ball_lost_d;
            in_play_q       <= in_play_d;
            pend_hit_q      <= pend_hit_d;
            pend_idx_q      <= pend_idx_d;
        end
    end

    assign ball_x        = ball_x_q;
    assign ball_y        = ball_y_q;
    assign dir           = dir_q;
    assign in_play       = in_play_q;
    assign brick_hit     = brick_hit_q;
    assign brick_hit_idx = brick_hit_idx_q;
    assign ball_lost     = ball_lost_q;

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: directed serve/wall/corner/brick scenarios plus a long
// randomized rally, all checked against a position-level model of the game rules.
module tb_ball_engine;

    localparam int CW = 10, SW = 640, SH = 480, XS = 1, YS = 1, PY = 20, PH = 40;
    localparam int COLS = 4, ROWS = 3, BW = 160, BH = 20, BX0 = 0, BY0 = 400;
    localparam int NB = 12, IW = 4, EXP_W = 28;

    logic          clk = 1'b0;
    logic          reset, tick, launch;
    logic [CW-1:0] paddle_x;
    logic [NB-1:0] brick_status;
    logic [CW-1:0] ball_x, ball_y;
    logic [1:0]    dir;
    logic          in_play, brick_hit, ball_lost;
    logic [IW-1:0] brick_hit_idx;

    int checks = 0;
    int failures = 0;
    logic [EXP_W-1:0] exp_q[$];

    int   m_x, m_y, m_d;
    bit   m_play;
    logic last_hit;
    logic [IW-1:0] last_idx;

    ball_engine dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .launch        (launch),
        .paddle_x      (paddle_x),
        .brick_status  (brick_status),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .dir           (dir),
        .in_play       (in_play),
        .brick_hit     (brick_hit),
        .brick_hit_idx (brick_hit_idx),
        .ball_lost     (ball_lost)
    );

    always #5 clk = ~clk;

    // One frame of the game rules: proposed move, bounces, brick strike, miss.
    task automatic model_step(input int px, input logic [NB-1:0] bs,
                              output int ex, output int ey, output int ed,
                              output int eh, output int ei, output int el);
        int nx, ny, d, col, row;
        bit yflip;
        d = m_d; eh = 0; ei = 0; el = 0; yflip = 0;
        nx = (m_d & 1) ? m_x - XS : m_x + XS;
        ny = (m_d & 2) ? m_y - YS : m_y + YS;
        if (nx < 0 || nx > SW - 1) d = d ^ 1;
        if ((m_d & 2) == 0 && ny > SH - 1) begin d = d ^ 2; yflip = 1; end
        if ((m_d & 2) != 0 && ny <= PY) begin
            if (nx >= px - PH && nx <= px + PH) begin d = d ^ 2; yflip = 1; end
            else el = 1;
        end
        if (!yflip && el == 0 && nx >= BX0 && nx < BX0 + COLS * BW && ny >= BY0 && ny < BY0 + ROWS * BH) begin
            col = (nx - BX0) / BW;
            row = (ny - BY0) / BH;
            if (bs[row * COLS + col]) begin d = d ^ 2; eh = 1; ei = row * COLS + col; end
        end
        if (el != 0) begin
            ex = m_x; ey = m_y; ed = m_d; m_play = 0;
        end else begin
            ex = (d & 1) ? m_x - XS : m_x + XS;
            ey = (d & 2) ? m_y - YS : m_y + YS;
            ed = d;
            m_x = ex; m_y = ey; m_d = d;
        end
    endtask

    task automatic do_abort();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        m_play = 0;
    endtask

    task automatic do_launch(input int px);
        paddle_x = CW'(px);
        @(negedge clk);
        checks++; if (ball_x !== CW'(px) || ball_y !== CW'(PY + 1) || in_play !== 1'b0) begin
            failures++; $display("FAIL idle_track: got (%0d,%0d) in_play=%0b want (%0d,%0d) in_play=0", ball_x, ball_y, in_play, px, PY + 1);
        end
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        checks++; if (in_play !== 1'b1 || dir !== 2'b00 || ball_x !== CW'(px) || ball_y !== CW'(PY + 1)) begin
            failures++; $display("FAIL launch: got (%0d,%0d) dir=%0d in_play=%0b want (%0d,%0d) dir=0 in_play=1", ball_x, ball_y, dir, in_play, px, PY + 1);
        end
        m_x = px; m_y = PY + 1; m_d = 0; m_play = 1;
    endtask

    // Issue one tick (optionally held into CHECK, where it must be ignored).
    task automatic do_tick(input int px, input bit long_tick);
        int ex, ey, ed, eh, ei, el;
        logic [EXP_W-1:0] e;
        logic [CW-1:0] oy, ox;
        logic [1:0] od;
        logic oh, ol;
        logic [IW-1:0] oi;
        paddle_x = CW'(px);
        model_step(px, brick_status, ex, ey, ed, eh, ei, el);
        exp_q.push_back({CW'(ex), CW'(ey), 2'(ed), eh[0], IW'(ei), el[0]});
        tick = 1'b1;
        @(negedge clk);
        if (!long_tick) tick = 1'b0;
        @(negedge clk);
        tick = 1'b0;
        checks++; if (ball_lost !== el[0] || in_play !== !el[0]) begin
            failures++; $display("FAIL check_stage: ball_lost=%0b in_play=%0b want ball_lost=%0b in_play=%0b", ball_lost, in_play, el[0], !el[0]);
        end
        if (el == 0) begin
            checks++; if (dir !== 2'(ed)) begin failures++; $display("FAIL dir_early: got %0d want %0d", dir, ed); end
        end
        @(negedge clk);
        e = exp_q.pop_front();
        {ox, oy, od, oh, oi, ol} = e;
        last_hit = brick_hit; last_idx = brick_hit_idx;
        checks++; if (ball_x !== ox || ball_y !== oy) begin
            failures++; $display("FAIL position: got (%0d,%0d) want (%0d,%0d)", ball_x, ball_y, ox, oy);
        end
        checks++; if (brick_hit !== oh || ball_lost !== 1'b0 || in_play !== !ol) begin
            failures++; $display("FAIL pulses: brick_hit=%0b ball_lost=%0b in_play=%0b want %0b 0 %0b", brick_hit, ball_lost, in_play, oh, !ol);
        end
        if (oh) begin
            checks++; if (brick_hit_idx !== oi) begin failures++; $display("FAIL brick_idx: got %0d want %0d", brick_hit_idx, oi); end
        end
        if (!ol) begin
            checks++; if (dir !== od) begin failures++; $display("FAIL dir: got %0d want %0d", dir, od); end
        end
        @(negedge clk);
        checks++; if (brick_hit !== 1'b0 || ball_lost !== 1'b0) begin
            failures++; $display("FAIL pulse_width: brick_hit=%0b ball_lost=%0b want 0 0", brick_hit, ball_lost);
        end
        if (ol) begin
            checks++; if (ball_x !== CW'(px) || ball_y !== CW'(PY + 1)) begin
                failures++; $display("FAIL lost_track: got (%0d,%0d) want (%0d,%0d)", ball_x, ball_y, px, PY + 1);
            end
        end else begin
            checks++; if (ball_x !== ox || ball_y !== oy) begin
                failures++; $display("FAIL hold: got (%0d,%0d) want (%0d,%0d)", ball_x, ball_y, ox, oy);
            end
        end
    endtask

    task automatic check_ball(input string name, input int ex, input int ey, input int ed);
        checks++; if (ball_x !== CW'(ex) || ball_y !== CW'(ey) || dir !== 2'(ed)) begin
            failures++; $display("FAIL %s: got (%0d,%0d) dir=%0d want (%0d,%0d) dir=%0d", name, ball_x, ball_y, dir, ex, ey, ed);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; launch = 1'b0; paddle_x = 10'd123; brick_status = '0;
        repeat (3) @(negedge clk);
        checks++; if (ball_x !== 10'd0 || ball_y !== CW'(PY + 1) || dir !== 2'b00 || in_play !== 1'b0 ||
                      brick_hit !== 1'b0 || brick_hit_idx !== '0 || ball_lost !== 1'b0) begin
            failures++; $display("FAIL reset: got (%0d,%0d) dir=%0d in_play=%0b hit=%0b idx=%0d lost=%0b want (0,21) 0 0 0 0 0",
                                 ball_x, ball_y, dir, in_play, brick_hit, brick_hit_idx, ball_lost);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ball_x !== 10'd123) begin failures++; $display("FAIL reset_release: ball_x=%0d want 123", ball_x); end
        m_play = 0;
    endtask

    task automatic test_serve();
        do_launch(320);
        do_tick(320, 0);
        check_ball("serve", 321, 22, 0);
        checks++; if (in_play !== 1'b1) begin failures++; $display("FAIL serve_in_play: got %0b want 1", in_play); end
    endtask

    task automatic test_reset_mid_flight();
        paddle_x = 10'd320;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (in_play !== 1'b0 || brick_hit !== 1'b0 || ball_lost !== 1'b0 || ball_x !== 10'd0 || ball_y !== CW'(PY + 1)) begin
            failures++; $display("FAIL abort: in_play=%0b hit=%0b lost=%0b (%0d,%0d) want 0 0 0 (0,21)", in_play, brick_hit, ball_lost, ball_x, ball_y);
        end
        @(negedge clk);
        checks++; if (ball_x !== 10'd320 || brick_hit !== 1'b0 || ball_lost !== 1'b0 || in_play !== 1'b0) begin
            failures++; $display("FAIL abort_idle: ball_x=%0d hit=%0b lost=%0b in_play=%0b want 320 0 0 0", ball_x, brick_hit, ball_lost, in_play);
        end
        m_play = 0;
    endtask

    task automatic test_tick_drop();
        do_launch(200);
        for (int i = 0; i < 3; i++) do_tick(200, 1);
        check_ball("tick_drop", 203, 24, 0);
    endtask

    task automatic test_right_wall();
        do_abort();
        brick_status = '0;
        do_launch(560);
        for (int i = 0; i < 80; i++) do_tick(560, 0);
        check_ball("right_wall", 638, 101, 1);
    endtask

    task automatic test_corner();
        do_abort();
        brick_status = '0;
        do_launch(181);
        for (int i = 0; i < 459; i++) do_tick(181, 0);
        check_ball("corner", 638, 478, 3);
    endtask

    task automatic test_brick(input int x0, input logic [NB-1:0] bs, input bit exp_hit,
                              input int exp_idx, input int ex, input int ey, input int ed);
        do_abort();
        brick_status = bs;
        do_launch(x0);
        for (int i = 0; i < 379; i++) do_tick(x0, 0);
        check_ball("brick_pos", ex, ey, ed);
        checks++; if (last_hit !== exp_hit || (exp_hit && last_idx !== IW'(exp_idx))) begin
            failures++; $display("FAIL brick_report: hit=%0b idx=%0d want hit=%0b idx=%0d", last_hit, last_idx, exp_hit, exp_idx);
        end
    endtask

    task automatic test_random_rally();
        int nx, ny, off, px;
        do_abort();
        brick_status = NB'($urandom);
        do_launch($urandom_range(0, SW - 1));
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) brick_status = NB'($urandom);
            nx = (m_d & 1) ? m_x - XS : m_x + XS;
            ny = (m_d & 2) ? m_y - YS : m_y + YS;
            if ((m_d & 2) != 0 && ny <= PY) begin
                case ($urandom_range(0, 5))
                    0: off = -41;
                    1: off = -40;
                    2: off = 40;
                    3: off = 41;
                    default: off = int'($urandom_range(0, 90)) - 45;
                endcase
                px = nx + off;
                if (px < 0) px = 0;
                if (px > 1023) px = 1023;
            end else begin
                px = $urandom_range(0, SW - 1);
            end
            do_tick(px, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (!m_play) do_launch($urandom_range(0, SW - 1));
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_reset_mid_flight();
        test_tick_drop();
        test_right_wall();
        test_corner();
        test_brick(100, 12'h004, 1'b1, 2, 479, 398, 2);
        test_brick(100, 12'h000, 1'b0, 0, 479, 400, 0);
        test_brick(101, 12'h008, 1'b1, 3, 480, 398, 2);
        test_random_rally();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Parametrised successor to the single-step ball mover for the Breakout datapath.
- Owns ball position and direction, and advances the ball one step per frame `tick`.
- Resolves wall, paddle and brick collisions with fixed priority, reports brick hits to the brick-status keeper, and signals a lost ball to game control.
- Includes serve/launch handling and all geometry as parameters.

Parameters:
- COORD_W, 10, coordinate width in bits.
- SCREEN_W, 640, playfield width; valid x is 0..SCREEN_W-1.
- SCREEN_H, 480, playfield height; valid y is 0..SCREEN_H-1; y=0 is the bottom.
- XSTEP, 1, x pixels moved per tick.
- YSTEP, 1, y pixels moved per tick.
- PADDLE_Y, 20, y of the paddle top surface.
- PADDLE_HALF, 40, paddle half-width; hit zone is inclusive.
- BRICK_COLS, 4, brick grid columns.
- BRICK_ROWS, 3, brick grid rows.
- BRICK_W, 160, brick width in pixels.
- BRICK_H, 20, brick height in pixels.
- BRICK_X0, 0, grid left x.
- BRICK_Y0, 400, grid bottom y.
- NUM_BRICKS is derived as BRICK_ROWS*BRICK_COLS. IDX_W is derived as $clog2(NUM_BRICKS).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, reset (see Behaviour).
- tick, input, 1, frame-rate step enable, one-cycle pulse.
- launch, input, 1, serve request.
- paddle_x, input, COORD_W, paddle centre x.
- brick_status, input, NUM_BRICKS, 1 = brick present.
- ball_x, output, COORD_W, ball x.
- ball_y, output, COORD_W, ball y.
- dir, output, 2, bit0 = moving left, bit1 = moving down; 00 is up-right.
- in_play, output, 1, high in states MOVE, CHECK and UPDATE.
- brick_hit, output, 1, one-cycle pulse when a brick is struck.
- brick_hit_idx, output, IDX_W, index of the struck brick; valid with brick_hit.
- ball_lost, output, 1, one-cycle pulse when the ball is missed.

Behaviour:
- Interface (already decided): one clock, `clk`. `reset` is synchronous and active-high.
- Reset values:
  - state = IDLE, dir = 00.
  - ball_x = 0, ball_y = PADDLE_Y+1.
  - brick_hit = 0, brick_hit_idx = 0, ball_lost = 0.
  - Reset mid-flight aborts to IDLE with no pulses emitted.
- IDLE:
  - Each cycle, ball_x <= paddle_x and ball_y <= PADDLE_Y+1 (ball rides the paddle).
  - On launch: dir <= 00 and state -> MOVE.
  - tick is ignored.
- MOVE: on tick -> CHECK. tick arriving in CHECK or UPDATE is dropped, not queued.
- CHECK (1 cycle): form nx = ball_x ± XSTEP and ny = ball_y ± YSTEP in COORD_W+1-bit signed arithmetic, so underflow reads as negative.
  - X wall: flip dir[0] if nx < 0 or nx > SCREEN_W-1.
  - Top wall: flip dir[1] if moving up and ny > SCREEN_H-1.
  - Paddle: if moving down and ny <= PADDLE_Y:
    - If paddle_x-PADDLE_HALF <= nx <= paddle_x+PADDLE_HALF, flip dir[1]. Compare in signed width; the paddle range may extend past the screen edges.
    - Otherwise -> LOST.
  - Brick: applies only if no y-flip came from the top wall or paddle. If (nx,ny) lies in the grid and brick_status[idx] = 1, flip dir[1] and latch idx.
  - The x-wall flip combines with any y-flip, so a corner hit flips both bits.
  - state -> UPDATE.
- UPDATE (1 cycle):
  - Step ball_x/ball_y by XSTEP/YSTEP using the new dir.
  - Pulse brick_hit with brick_hit_idx if a brick was latched.
  - state -> MOVE.
- LOST (1 cycle): pulse ball_lost; ball_x/ball_y hold; state -> IDLE.
- Latency: tick in cycle t; the new position and brick_hit are visible at t+2.
- Brick index:
  - col = (nx-BRICK_X0)/BRICK_W, row = (ny-BRICK_Y0)/BRICK_H, idx = row*BRICK_COLS + col.
  - Grid edges are inclusive-low, exclusive-high.
  - Outside the grid gives valid = 0.
  - Division is implemented as a comparator chain, with no divider.
- brick_status is sampled combinationally in CHECK. Clearing bricks is the keeper's job.

Decomposition:
- Package ball_pkg holds:
  - Direction constants DIR_UR=00, DIR_UL=01, DIR_DR=10, DIR_DL=11.
  - State enum IDLE/MOVE/CHECK/UPDATE/LOST.
- Sub-module ball_brick_lookup: combinational (nx,ny) -> {valid, idx}, parametrised by the grid parameters.

Test Plan:
- Serve: reset, paddle_x=320, launch, tick -> ball (320,21) in IDLE, then (321,22), dir 00, in_play=1.
- Right wall: ball (639,100) dir 00, tick -> dir 01, ball (638,101) two cycles later, no pulses.
- Corner: ball (639,479) dir 00, tick -> dir 11, ball (638,478).
- Paddle: ball (300,21) dir 10, paddle_x=320, tick -> dir 00, ball (301,22).
- Paddle miss: ball (100,21) dir 10, paddle_x=320, tick -> ball_lost pulse for one cycle, IDLE, ball tracks paddle. Edge case: paddle_x=60, nx=20 -> paddle hit (inclusive).
- Brick: ball (170,399) dir 00, brick_status=12'h002, tick -> brick_hit with idx=1, dir 10, ball (171,398). Same case with brick_status=0 -> no hit, ball (171,400).
